// File: rtl/pk_link.sv
// pk_link: serial control-panel link for the P-K emulation.
// Decodes panel command bytes into keys, function keys and rotary position; returns snapshotted status frames.
module pk_link #(
    parameter int unsigned    NBANK       = 1,
    parameter int unsigned    NFN         = 12,
    parameter logic [NFN-1:0] MONO_MASK   = 12'hFF8,
    parameter int unsigned    PULSE_TICKS = 20,
    parameter int unsigned    NSTAT       = 4,
    parameter logic [3:0]     ROT_INIT    = 4'b0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_strobe,
    output logic [16*NBANK-1:0]  keys,
    output logic [NFN-1:0]       fnkey,
    output logic [3:0]           rot_pos,
    input  logic [8*NSTAT-1:0]   status,
    output logic [7:0]           tx_byte,
    output logic                 send,
    input  logic                 tx_busy,
    output logic                 stat_busy
);
    localparam int unsigned   CW         = $clog2(PULSE_TICKS + 1);
    localparam int unsigned   BW         = (NSTAT > 1) ? $clog2(NSTAT) : 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_TICKS);
    localparam logic [CW-1:0] PULSE_LAST = CW'(1);
    localparam logic [BW-1:0] LAST_BYTE  = BW'(NSTAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_TRANS} stat_state_t;

    stat_state_t        state;
    logic [3:0]         bank;
    logic [CW-1:0]      pulse_cnt [NFN];
    logic               pending;
    logic [8*NSTAT-1:0] shadow;
    logic [BW-1:0]      byte_cnt;

    logic [2:0] opcode;
    logic [3:0] fn_idx;
    logic       stat_req;

    assign opcode    = rx_byte[7:5];
    assign fn_idx    = rx_byte[4:1];
    assign stat_req  = rx_strobe && (opcode == 3'b110);
    assign stat_busy = (state != IDLE) || pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys    <= '0;
            fnkey   <= '0;
            rot_pos <= ROT_INIT;
            bank    <= '0;
            for (int unsigned i = 0; i < NFN; i++) pulse_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NFN; i++) begin
                if (MONO_MASK[i] && pulse_cnt[i] != '0) begin
                    pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
                    fnkey[i]     <= (pulse_cnt[i] != PULSE_LAST);
                end
            end
            // Command decode follows the expiry logic so a same-cycle command overrides it.
            if (rx_strobe) begin
                case (opcode)
                    3'b000: if (rx_byte[4] && 32'(rx_byte[3:0]) < NBANK) bank <= rx_byte[3:0];
                    3'b001: begin
                        if (32'(fn_idx) < NFN) begin
                            if (MONO_MASK[fn_idx]) pulse_cnt[fn_idx] <= rx_byte[0] ? PULSE_LOAD : '0;
                            fnkey[fn_idx] <= rx_byte[0];
                        end
                    end
                    3'b010, 3'b011: keys[16*bank +: 6]      <= rx_byte[5:0];
                    3'b100:         keys[16*bank + 6 +: 5]  <= rx_byte[4:0];
                    3'b101:         keys[16*bank + 11 +: 5] <= rx_byte[4:0];
                    3'b111:         rot_pos <= rx_byte[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= 1'b0;
            shadow   <= '0;
            byte_cnt <= '0;
            tx_byte  <= '0;
            send     <= 1'b0;
        end else begin
            // A request landing on the cycle IDLE consumes the pending one is dropped.
            if (stat_req && !(state == IDLE && pending)) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (pending && !tx_busy) begin
                        pending <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    shadow   <= status;
                    byte_cnt <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    // Shadow shifts out MSB-first, so byte 0 is always at the top.
                    tx_byte <= shadow[8*NSTAT-1 -: 8];
                    shadow  <= shadow << 8;
                    send    <= 1'b1;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        send  <= 1'b0;
                        state <= WAIT_TRANS;
                    end
                end
                WAIT_TRANS: begin
                    if (!tx_busy) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
